// File: rtl/cpu_trace_pkg.sv
// Shared types for the retirement trace path: the stored record layout and counter widths.
// Record fields are sized for the widest supported CPU (32-bit PC and data).
package cpu_trace_pkg;

    localparam int TRC_AW     = 32;
    localparam int TRC_DW     = 32;
    localparam int DROP_CNT_W = 16;
    localparam int RET_CNT_W  = 32;

    typedef struct packed {
        logic [TRC_AW-1:0] pc;
        logic              rf_we;
        logic [4:0]        rd;
        logic [TRC_DW-1:0] rf_wdata;
        logic              mem_we;
        logic [TRC_AW-1:0] mem_addr;
        logic [TRC_DW-1:0] mem_wdata;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace record storage: registered write at the tail pointer, asynchronous read of the head.
// Contents are deliberately not reset; occupancy tracking lives in the parent.
module trace_fifo_mem #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [PW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/retire_trace_fifo.sv
// Commit-trace buffer: captures one retired instruction per cycle into a show-ahead FIFO,
// with sticky overflow, saturating drop count and a free-running retirement count.
module retire_trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int DEPTH      = 16,
    parameter int FILTER_NOP = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ret_valid_i,
    input  logic [AW-1:0]            ret_pc_i,
    input  logic                     ret_rf_we_i,
    input  logic [4:0]               ret_rd_i,
    input  logic [DW-1:0]            ret_rf_wdata_i,
    input  logic                     ret_mem_we_i,
    input  logic [AW-1:0]            ret_mem_addr_i,
    input  logic [DW-1:0]            ret_mem_wdata_i,
    input  logic                     freeze_i,
    output logic                     trc_valid_o,
    input  logic                     trc_ready_i,
    output logic [AW-1:0]            trc_pc_o,
    output logic                     trc_rf_we_o,
    output logic [4:0]               trc_rd_o,
    output logic [DW-1:0]            trc_rf_wdata_o,
    output logic                     trc_mem_we_o,
    output logic [AW-1:0]            trc_mem_addr_o,
    output logic [DW-1:0]            trc_mem_wdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o,
    output logic [DROP_CNT_W-1:0]    drop_cnt_o,
    output logic [RET_CNT_W-1:0]     ret_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [RET_CNT_W-1:0]  ret_cnt_q, ret_cnt_d;

    logic         eligible, want_push, push, pop, full, rd_zero, dropped;
    trace_entry_t wr_entry, head;

    always_comb begin
        eligible  = ret_valid_i & ~freeze_i;
        want_push = eligible & ((FILTER_NOP == 0) | ret_rf_we_i | ret_mem_we_i);
        full      = (level_q == FULL_LVL);
        pop       = (level_q != '0) & trc_ready_i;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push      = want_push & (~full | pop);
        dropped   = want_push & ~push;
        rd_zero   = (ret_rd_i == 5'd0);

        wr_entry          = '0;
        wr_entry.pc       = TRC_AW'(ret_pc_i);
        wr_entry.rd       = ret_rd_i;
        wr_entry.rf_we    = ret_rf_we_i & ~rd_zero;
        wr_entry.rf_wdata = rd_zero ? '0 : TRC_DW'(ret_rf_wdata_i);
        wr_entry.mem_we   = ret_mem_we_i;
        if (ret_mem_we_i) begin
            wr_entry.mem_addr  = TRC_AW'(ret_mem_addr_i);
            wr_entry.mem_wdata = TRC_DW'(ret_mem_wdata_i);
        end

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        ovf_d    = ovf_q | dropped;

        drop_cnt_d = drop_cnt_q;
        if (dropped && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
        ret_cnt_d = ret_cnt_q + RET_CNT_W'(eligible);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            ret_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            ret_cnt_q  <= ret_cnt_d;
        end
    end

    trace_fifo_mem #(
        .W     ($bits(trace_entry_t)),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign trc_valid_o     = (level_q != '0);
    assign trc_pc_o        = head.pc[AW-1:0];
    assign trc_rf_we_o     = head.rf_we;
    assign trc_rd_o        = head.rd;
    assign trc_rf_wdata_o  = head.rf_wdata[DW-1:0];
    assign trc_mem_we_o    = head.mem_we;
    assign trc_mem_addr_o  = head.mem_addr[AW-1:0];
    assign trc_mem_wdata_o = head.mem_wdata[DW-1:0];
    assign level_o         = level_q;
    assign ovf_o           = ovf_q;
    assign drop_cnt_o      = drop_cnt_q;
    assign ret_cnt_o       = ret_cnt_q;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Bench for retire_trace_fifo: two instances (unfiltered and NOP-filtered) share one stimulus
// stream and are compared every cycle against a queue-based model, plus literal spot checks.
module tb_retire_trace_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ret_valid = 1'b0, ret_rf_we = 1'b0, ret_mem_we = 1'b0;
    logic        freeze = 1'b0, ready = 1'b0;
    logic [31:0] ret_pc = '0, ret_rf_wdata = '0, ret_mem_addr = '0, ret_mem_wdata = '0;
    logic [4:0]  ret_rd = '0;

    logic        o_valid [2];
    logic [31:0] o_pc    [2];
    logic        o_rfwe  [2];
    logic [4:0]  o_rd    [2];
    logic [31:0] o_rfwd  [2];
    logic        o_mwe   [2];
    logic [31:0] o_maddr [2];
    logic [31:0] o_mwd   [2];
    logic [4:0]  o_level [2];
    logic        o_ovf   [2];
    logic [15:0] o_drop  [2];
    logic [31:0] o_cnt   [2];

    always #5 clk = ~clk;

    retire_trace_fifo #(.AW(32), .DW(32), .DEPTH(DEPTH), .FILTER_NOP(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .ret_valid_i(ret_valid), .ret_pc_i(ret_pc),
        .ret_rf_we_i(ret_rf_we), .ret_rd_i(ret_rd), .ret_rf_wdata_i(ret_rf_wdata),
        .ret_mem_we_i(ret_mem_we), .ret_mem_addr_i(ret_mem_addr), .ret_mem_wdata_i(ret_mem_wdata),
        .freeze_i(freeze), .trc_valid_o(o_valid[0]), .trc_ready_i(ready),
        .trc_pc_o(o_pc[0]), .trc_rf_we_o(o_rfwe[0]), .trc_rd_o(o_rd[0]),
        .trc_rf_wdata_o(o_rfwd[0]), .trc_mem_we_o(o_mwe[0]), .trc_mem_addr_o(o_maddr[0]),
        .trc_mem_wdata_o(o_mwd[0]), .level_o(o_level[0]), .ovf_o(o_ovf[0]),
        .drop_cnt_o(o_drop[0]), .ret_cnt_o(o_cnt[0])
    );

    retire_trace_fifo #(.AW(32), .DW(32), .DEPTH(DEPTH), .FILTER_NOP(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .ret_valid_i(ret_valid), .ret_pc_i(ret_pc),
        .ret_rf_we_i(ret_rf_we), .ret_rd_i(ret_rd), .ret_rf_wdata_i(ret_rf_wdata),
        .ret_mem_we_i(ret_mem_we), .ret_mem_addr_i(ret_mem_addr), .ret_mem_wdata_i(ret_mem_wdata),
        .freeze_i(freeze), .trc_valid_o(o_valid[1]), .trc_ready_i(ready),
        .trc_pc_o(o_pc[1]), .trc_rf_we_o(o_rfwe[1]), .trc_rd_o(o_rd[1]),
        .trc_rf_wdata_o(o_rfwd[1]), .trc_mem_we_o(o_mwe[1]), .trc_mem_addr_o(o_maddr[1]),
        .trc_mem_wdata_o(o_mwd[1]), .level_o(o_level[1]), .ovf_o(o_ovf[1]),
        .drop_cnt_o(o_drop[1]), .ret_cnt_o(o_cnt[1])
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rd;
        logic [31:0] rf_wdata;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } rec_t;

    rec_t        mq [2][$];
    int unsigned mcnt [2] = '{0, 0};
    int          mdrop [2] = '{0, 0};
    bit          movf [2] = '{0, 0};
    rec_t        tmp;
    int          nerr = 0;
    int          nchk = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic rec_t norm_rec();
        rec_t r;
        r.pc        = ret_pc;
        r.rd        = ret_rd;
        r.rf_we     = (ret_rd == 0) ? 1'b0 : ret_rf_we;
        r.rf_wdata  = (ret_rd == 0) ? 32'd0 : ret_rf_wdata;
        r.mem_we    = ret_mem_we;
        r.mem_addr  = ret_mem_we ? ret_mem_addr : 32'd0;
        r.mem_wdata = ret_mem_we ? ret_mem_wdata : 32'd0;
        return r;
    endfunction

    // Reference model: queue of records per instance, instance 1 filters writeless retirements.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                mcnt[k]  = 0;
                mdrop[k] = 0;
                movf[k]  = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (mq[k].size() != 0 && ready) tmp = mq[k].pop_front();
                if (ret_valid && !freeze) begin
                    mcnt[k]++;
                    if (k == 0 || ret_rf_we || ret_mem_we) begin
                        if (mq[k].size() < DEPTH) mq[k].push_back(norm_rec());
                        else begin
                            movf[k] = 1;
                            if (mdrop[k] != 16'hFFFF) mdrop[k]++;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("d%0d valid", k), o_valid[k], mq[k].size() != 0);
                chk($sformatf("d%0d level", k), o_level[k], mq[k].size());
                chk($sformatf("d%0d ovf", k), o_ovf[k], movf[k]);
                chk($sformatf("d%0d drop", k), o_drop[k], mdrop[k]);
                chk($sformatf("d%0d ret_cnt", k), o_cnt[k], mcnt[k]);
                if (mq[k].size() != 0)
                    chk($sformatf("d%0d head", k),
                        {o_pc[k], o_rfwe[k], o_rd[k], o_rfwd[k], o_mwe[k], o_maddr[k], o_mwd[k]},
                        mq[k][0]);
            end
        end
    end

    task automatic ret(input logic [31:0] pc, input logic rfwe, input logic [4:0] rd,
                       input logic [31:0] wd, input logic mwe, input logic [31:0] ma,
                       input logic [31:0] md);
        ret_valid = 1'b1; ret_pc = pc; ret_rf_we = rfwe; ret_rd = rd; ret_rf_wdata = wd;
        ret_mem_we = mwe; ret_mem_addr = ma; ret_mem_wdata = md;
        @(posedge clk); #1;
        ret_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        ret_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset valid", o_valid[0], 1'b0);
        chk("reset level", o_level[0], 5'd0);
        chk("reset cnt", o_cnt[0], 32'd0);

        // Three retirements streamed through with the consumer always ready.
        ready = 1'b1;
        ret(32'h0, 1, 5'd1, 32'd10, 0, 0, 0);
        chk("t1 latency valid", o_valid[0], 1'b1);
        chk("t1 head pc0", o_pc[0], 32'h0);
        chk("t1 head wdata0", o_rfwd[0], 32'd10);
        ret(32'h4, 1, 5'd2, 32'd20, 0, 0, 0);
        chk("t1 head pc1", o_pc[0], 32'h4);
        ret(32'h8, 1, 5'd3, 32'd30, 0, 0, 0);
        chk("t1 head pc2", o_pc[0], 32'h8);
        chk("t1 head rd2", o_rd[0], 5'd3);
        idle(1);
        chk("t1 level", o_level[0], 5'd0);
        chk("t1 cnt", o_cnt[0], 32'd3);

        // Overflow: 20 retirements with the consumer stalled.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 20; i++) ret(32'(i * 4), 1, 5'(i % 31 + 1), 32'(i), 0, 0, 0);
        chk("t2 level", o_level[0], 5'd16);
        chk("t2 ovf", o_ovf[0], 1'b1);
        chk("t2 drop", o_drop[0], 16'd4);
        chk("t2 cnt", o_cnt[0], 32'd20);
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2 drain pc", o_pc[0], 32'(i * 4));
            @(posedge clk); #1;
        end
        chk("t2 empty", o_valid[0], 1'b0);
        ready = 1'b0;

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 16; i++) ret(32'h200 + 32'(i * 4), 1, 5'd7, 32'(i), 0, 0, 0);
        ready = 1'b1;
        ret(32'h300, 1, 5'd8, 32'h77, 0, 0, 0);
        chk("t3 level", o_level[0], 5'd16);
        chk("t3 drop", o_drop[0], 16'd0);
        chk("t3 ovf", o_ovf[0], 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("t3 drain pc", o_pc[0], (i == 15) ? 32'h300 : 32'h204 + 32'(i * 4));
            @(posedge clk); #1;
        end
        ready = 1'b0;

        // Normalisation of rd=0 and of unused memory fields.
        do_reset();
        ret(32'h40, 1, 5'd0, 32'hDEADBEEF, 1, 32'h7C, 32'h55);
        ret(32'h44, 1, 5'd5, 32'h11, 0, 32'hABC, 32'h99);
        chk("t4 rf_we", o_rfwe[0], 1'b0);
        chk("t4 rf_wdata", o_rfwd[0], 32'd0);
        chk("t4 mem_we", o_mwe[0], 1'b1);
        chk("t4 mem_addr", o_maddr[0], 32'h7C);
        chk("t4 mem_wdata", o_mwd[0], 32'h55);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        chk("t4 pc2", o_pc[0], 32'h44);
        chk("t4 mem_addr2", o_maddr[0], 32'd0);
        chk("t4 mem_wdata2", o_mwd[0], 32'd0);
        chk("t4 rf_wdata2", o_rfwd[0], 32'h11);

        // NOP filtering, then freeze.
        do_reset();
        ret(32'h0, 1, 5'd1, 32'd1, 0, 0, 0);
        ret(32'h4, 0, 5'd0, 32'd0, 0, 0, 0);
        ret(32'h8, 1, 5'd2, 32'd2, 0, 0, 0);
        chk("t5 filt level", o_level[1], 5'd2);
        chk("t5 filt cnt", o_cnt[1], 32'd3);
        chk("t5 nofilt level", o_level[0], 5'd3);
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) ret(32'h100 + 32'(i * 4), 1, 5'd4, 32'd9, 0, 0, 0);
        freeze = 1'b0;
        chk("t5 frz level", o_level[1], 5'd2);
        chk("t5 frz cnt", o_cnt[1], 32'd3);
        chk("t5 frz cnt0", o_cnt[0], 32'd3);

        // Asynchronous reset mid-cycle with a partly filled, overflowed FIFO.
        do_reset();
        for (int i = 0; i < 17; i++) ret(32'h400 + 32'(i * 4), 1, 5'd6, 32'(i), 0, 0, 0);
        ready = 1'b1;
        idle(9);
        ready = 1'b0;
        chk("t6 level pre", o_level[0], 5'd7);
        chk("t6 ovf pre", o_ovf[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t6 async valid", o_valid[0], 1'b0);
        chk("t6 async level", o_level[0], 5'd0);
        chk("t6 async ovf", o_ovf[0], 1'b0);
        chk("t6 async drop", o_drop[0], 16'd0);
        chk("t6 async cnt", o_cnt[0], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ret(32'h500, 1, 5'd9, 32'h5, 0, 0, 0);
        chk("t6 next cnt", o_cnt[0], 32'd1);
        chk("t6 next pc", o_pc[0], 32'h500);
        chk("t6 next level", o_level[0], 5'd1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
- Synthesizable commit-trace buffer for the single-cycle and pipelined CPU generations.
- Each cycle it captures one retired instruction: PC, register-file write, and data-memory write.
- Captured records are queued in a parametrised FIFO and drained by a checker or debug port over a valid/ready interface.
- It replaces per-cycle hierarchical probing of PC, RF and DM with an ordered, loss-accounted record stream.

Parameters:
- AW, 32: PC and data-memory address width.
- DW, 32: register and memory data width.
- DEPTH, 16: FIFO entries; must be a power of 2 and at least 2.
- FILTER_NOP, 0: when 1, retirements with neither an RF write nor a memory write are not enqueued; they are still counted.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ret_valid_i  in  1  one instruction retires this cycle.
- ret_pc_i  in  AW  PC of the retiring instruction.
- ret_rf_we_i  in  1  register-file write enable.
- ret_rd_i  in  5  destination register.
- ret_rf_wdata_i  in  DW  register write data.
- ret_mem_we_i  in  1  data-memory word write enable.
- ret_mem_addr_i  in  AW  byte address of the memory write.
- ret_mem_wdata_i  in  DW  memory write data.
- freeze_i  in  1  level input; while high, nothing is captured or counted.
- trc_valid_o  out  1  head entry available.
- trc_ready_i  in  1  consumer accepts the head entry.
- trc_pc_o, trc_rf_we_o, trc_rd_o, trc_rf_wdata_o, trc_mem_we_o, trc_mem_addr_o, trc_mem_wdata_o  out  as the matching inputs  head entry fields.
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- ovf_o  out  1  sticky overflow flag.
- drop_cnt_o  out  16  dropped entries, saturating at 16'hFFFF.
- ret_cnt_o  out  32  retirements seen while not frozen; wraps modulo 2^32.

Behaviour:
- Reset (asynchronous, rst_i high; takes effect immediately and mid-operation):
  - pointers 0, level_o 0, trc_valid_o 0, ovf_o 0, drop_cnt_o 0, ret_cnt_o 0.
  - The storage array is not reset.
  - An entry in flight at reset assertion is lost; no partial state survives.
- Capture:
  - A retirement is eligible when ret_valid_i & ~freeze_i.
  - An eligible retirement increments ret_cnt_o.
  - With FILTER_NOP=1, an eligible retirement where ret_rf_we_i==0 and ret_mem_we_i==0 is counted but not pushed.
- Normalisation at capture:
  - When ret_rd_i==0, the stored rf_we is 0 and the stored rf_wdata is 0, mirroring $zero semantics.
  - When ret_mem_we_i==0, the stored mem_addr and mem_wdata are 0.
- Read side (show-ahead):
  - trc_* outputs present storage[rd_ptr]; trc_valid_o = (level_o != 0).
  - Pop occurs when trc_valid_o & trc_ready_i.
  - Head fields are stable while trc_valid_o is high and no pop occurs.
- Latency:
  - A push in cycle N is visible on trc_valid_o in cycle N+1.
  - There is no same-cycle bypass from input to output when the FIFO is empty.
- Full condition: level_o==DEPTH.
  - Push while full with no pop in the same cycle: the entry is dropped, ovf_o is set (sticky until reset), and drop_cnt_o increments (saturating).
  - Push while full with a pop in the same cycle: both are accepted; level is unchanged and nothing is dropped.
- Empty condition: trc_ready_i is ignored; pointers and level are unchanged.
- Simultaneous push and pop at any non-empty level: level is unchanged and both pointers advance.
- Pointer arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - level_o is an explicit counter, not derived from pointer difference.
- Ordering: records emerge in strict retirement order; none are duplicated or reordered.
- No state machine beyond the FIFO control.
- Counters are independent of trc_ready_i backpressure. The block never stalls the CPU; loss is accounted for through ovf_o and drop_cnt_o only.

Decomposition:
- Shared package cpu_trace_pkg:
  - trace_entry_t packed struct (pc, rf_we, rd, rf_wdata, mem_we, mem_addr, mem_wdata).
  - DROP_CNT_W = 16 and RET_CNT_W = 32 constants.
- One natural sub-module: trace_fifo_mem, a parametric dual-pointer storage array with registered write and asynchronous read of the head. The capture, filter and counter logic stays in the top module.

Test Plan:
- Reset, then 3 retirements (pc 0x0, 0x4, 0x8; rd 1, 2, 3; wdata 10, 20, 30) with trc_ready_i=1 -> each record appears one cycle after capture, in order; ret_cnt_o=3; level_o returns to 0.
- trc_ready_i=0 and 20 consecutive retirements with DEPTH=16 -> level_o=16, ovf_o=1, drop_cnt_o=4; the drained records are pc 0x0..0x3C; ret_cnt_o=20.
- Full FIFO, retirement and pop in the same cycle -> level_o stays 16; no drop; the new record becomes the tail.
- Retirement with rd=0 and wdata 0xDEADBEEF, plus a SW to addr 0x7C with data 0x55 -> record has rf_we=0, rf_wdata=0, mem_we=1, mem_addr=0x7C, mem_wdata=0x55.
- FILTER_NOP=1 with a branch retirement (no writes) between two ADDIs -> 2 records queued, ret_cnt_o=3. Then freeze_i=1 for 5 retirements -> nothing changes.
- Assert rst_i asynchronously mid-cycle with level_o=7, ovf_o=1 -> all outputs clear immediately without waiting for a clock edge; the next retirement is record 0 with ret_cnt_o=1.
